// File: rtl/axil_regfile_slave.sv
// AXI-lite-style register-file slave: independent AW/W/B and AR/R channels, 1-cycle read latency.
// Optional SLVERR responses for out-of-range accesses when AXIL_REGFILE_ERR_RESP_EN is defined.
module axil_regfile_slave #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 8,
  parameter int LED_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic [DATA_W-1:0] led_reg
);

`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_VALID} rstate_t;

  wstate_t             wstate_q, wstate_d;
  rstate_t             rstate_q, rstate_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [1:0]          b_resp_q, b_resp_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic [DATA_W-1:0]   led_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                aw_hs, w_hs, ar_hs, commit, cm_hit, rd_hit;
  logic [ADDR_W-1:0]   cm_addr;
  logic [DATA_W-1:0]   cm_data, rd_data;

  assign aw_ready = !rst && (wstate_q == W_IDLE || wstate_q == W_HAVE_W);
  assign w_ready  = !rst && (wstate_q == W_IDLE || wstate_q == W_HAVE_AW);
  assign b_valid  = !rst && (wstate_q == W_RESP);
  assign ar_ready = !rst && (rstate_q == R_IDLE);
  assign r_valid  = !rst && (rstate_q == R_VALID);
  assign b_resp   = b_resp_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign led_reg  = led_q;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign ar_hs = ar_valid && ar_ready;

  // Whichever half arrived earlier comes from its latch, the other straight from the bus.
  assign cm_addr = (wstate_q == W_HAVE_AW) ? aw_addr_q : aw_addr;
  assign cm_data = (wstate_q == W_HAVE_W)  ? w_data_q  : w_data;

  always_comb begin
    wstate_d  = wstate_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    b_resp_d  = b_resp_q;
    commit    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          wstate_d  = W_RESP;
        end else if (aw_hs) begin
          aw_addr_d = aw_addr;
          wstate_d  = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d  = w_data;
          wstate_d  = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        commit   = 1'b1;
        wstate_d = W_RESP;
      end
      W_HAVE_W: if (aw_hs) begin
        commit   = 1'b1;
        wstate_d = W_RESP;
      end
      W_RESP: if (b_ready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase

    cm_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (cm_addr == ADDR_W'(i)) begin
        cm_hit = 1'b1;
        if (commit) mem_d[i] = cm_data;
      end
    end
    if (commit) b_resp_d = cm_hit ? 2'b00 : OOR_RESP;
  end

  always_comb begin
    rstate_d = rstate_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    rd_hit   = 1'b0;
    rd_data  = '0;
    // Reads sample mem_q, so a same-edge write is not yet visible.
    for (int i = 0; i < DEPTH; i++) begin
      if (ar_addr == ADDR_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = mem_q[i];
      end
    end
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        r_data_d = rd_data;
        r_resp_d = rd_hit ? 2'b00 : OOR_RESP;
        rstate_d = R_VALID;
      end
      R_VALID: if (r_ready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      b_resp_q  <= 2'b00;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
      led_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      b_resp_q  <= b_resp_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      led_q     <= mem_q[LED_IDX];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave (DEPTH=6 build); expected responses follow AXIL_REGFILE_ERR_RESP_EN.
module tb_axil_regfile_slave;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 6;

`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aw_valid = 1'b0, aw_ready;
  logic [ADDR_W-1:0] aw_addr = '0;
  logic              w_valid = 1'b0, w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              b_valid, b_ready = 1'b0;
  logic [1:0]        b_resp;
  logic              ar_valid = 1'b0, ar_ready;
  logic [ADDR_W-1:0] ar_addr = '0;
  logic              r_valid, r_ready = 1'b0;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] led_reg;

  int tests = 0;
  int fails = 0;

  axil_regfile_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LED_IDX(0)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .led_reg(led_reg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output logic [1:0] resp);
    int n = 0;
    aw_valid = 1'b1; aw_addr = a; w_valid = 1'b1; w_data = d;
    while (!(aw_ready && w_ready) && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("write_addr");
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    n = 0;
    while (!b_valid && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("write_resp");
    resp = b_resp;
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic [1:0] resp);
    int n = 0;
    ar_valid = 1'b1; ar_addr = a;
    while (!ar_ready && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("read_addr");
    tick();
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("read_data");
    d = r_data; resp = r_resp;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    rst = 1'b1;
    tick(); tick();
    tests++; if ({aw_ready, w_ready, ar_ready, b_valid, r_valid} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 00000", {aw_ready, w_ready, ar_ready, b_valid, r_valid});
    end
    tests++; if (led_reg !== 4'h0 || r_data !== 4'h0 || b_resp !== 2'b00 || r_resp !== 2'b00) begin
      fails++; $display("FAIL reset_data: led=%h r_data=%h b_resp=%b r_resp=%b want 0", led_reg, r_data, b_resp, r_resp);
    end
    rst = 1'b0;
    tick();
    tests++; if ({aw_ready, w_ready, ar_ready, b_valid, r_valid} !== 5'b11100) begin
      fails++; $display("FAIL post_reset_ready: got %b want 11100", {aw_ready, w_ready, ar_ready, b_valid, r_valid});
    end
    do_read(3'd5, d, rs);
    tests++; if (d !== 4'h0 || rs !== 2'b00) begin
      fails++; $display("FAIL reset_read5: got %h/%b want 0/00", d, rs);
    end
  endtask

  task automatic test_order();
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    // AW first, W two cycles later.
    aw_valid = 1'b1; aw_addr = 3'd3;
    tick();
    aw_valid = 1'b0;
    tests++; if ({aw_ready, w_ready} !== 2'b01) begin
      fails++; $display("FAIL have_aw_ready: got %b want 01", {aw_ready, w_ready});
    end
    tick();
    w_valid = 1'b1; w_data = 4'hA;
    tests++; if (b_valid !== 1'b0) begin
      fails++; $display("FAIL early_bvalid_aw: got %b want 0", b_valid);
    end
    tick();
    w_valid = 1'b0;
    tests++; if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      fails++; $display("FAIL aw_first_b: got %b/%b want 1/00", b_valid, b_resp);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    tests++; if (b_valid !== 1'b0) begin
      fails++; $display("FAIL b_drop: got %b want 0", b_valid);
    end
    do_read(3'd3, d, rs);
    tests++; if (d !== 4'hA || rs !== 2'b00) begin
      fails++; $display("FAIL read3: got %h/%b want a/00", d, rs);
    end
    // W first, AW two cycles later.
    w_valid = 1'b1; w_data = 4'hC;
    tick();
    w_valid = 1'b0;
    tests++; if ({aw_ready, w_ready} !== 2'b10) begin
      fails++; $display("FAIL have_w_ready: got %b want 10", {aw_ready, w_ready});
    end
    tick();
    aw_valid = 1'b1; aw_addr = 3'd4;
    tick();
    aw_valid = 1'b0;
    tests++; if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      fails++; $display("FAIL w_first_b: got %b/%b want 1/00", b_valid, b_resp);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    do_read(3'd4, d, rs);
    tests++; if (d !== 4'hC || rs !== 2'b00) begin
      fails++; $display("FAIL read4: got %h/%b want c/00", d, rs);
    end
  endtask

  task automatic test_backpressure();
    aw_valid = 1'b1; aw_addr = 3'd0; w_valid = 1'b1; w_data = 4'h7;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    tests++; if (led_reg !== 4'h0) begin
      fails++; $display("FAIL led_early: got %h want 0", led_reg);
    end
    for (int i = 0; i < 5; i++) begin
      tests++; if ({b_valid, aw_ready, w_ready} !== 3'b100 || b_resp !== 2'b00) begin
        fails++; $display("FAIL hold_b cycle %0d: got %b resp %b want 100 resp 00", i, {b_valid, aw_ready, w_ready}, b_resp);
      end
      if (i == 1) begin
        tests++; if (led_reg !== 4'h7) begin
          fails++; $display("FAIL led_update: got %h want 7", led_reg);
        end
      end
      tick();
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    tests++; if (b_valid !== 1'b0 || led_reg !== 4'h7) begin
      fails++; $display("FAIL after_bp: b_valid=%b led=%h want 0/7", b_valid, led_reg);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    do_write(3'd2, 4'h1, rs);
    aw_valid = 1'b1; aw_addr = 3'd2; w_valid = 1'b1; w_data = 4'h9;
    ar_valid = 1'b1; ar_addr = 3'd2;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    tests++; if (r_valid !== 1'b1 || r_data !== 4'h1 || b_valid !== 1'b1) begin
      fails++; $display("FAIL collision_old: r_valid=%b r_data=%h b_valid=%b want 1/1/1", r_valid, r_data, b_valid);
    end
    b_ready = 1'b1; r_ready = 1'b1; tick(); b_ready = 1'b0; r_ready = 1'b0;
    do_read(3'd2, d, rs);
    tests++; if (d !== 4'h9) begin
      fails++; $display("FAIL collision_new: got %h want 9", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    logic [DATA_W-1:0] exp_mem [DEPTH];
    exp_mem[0] = 4'h7; exp_mem[1] = 4'h0; exp_mem[2] = 4'h9;
    exp_mem[3] = 4'hA; exp_mem[4] = 4'hC; exp_mem[5] = 4'h0;
    do_write(3'd6, 4'hF, rs);
    tests++; if (rs !== EXP_OOR) begin
      fails++; $display("FAIL oor_b_resp: got %b want %b", rs, EXP_OOR);
    end
    do_read(3'd6, d, rs);
    tests++; if (d !== 4'h0 || rs !== EXP_OOR) begin
      fails++; $display("FAIL oor_read6: got %h/%b want 0/%b", d, rs, EXP_OOR);
    end
    do_write(3'd7, 4'hE, rs);
    do_read(3'd7, d, rs);
    tests++; if (d !== 4'h0 || rs !== EXP_OOR) begin
      fails++; $display("FAIL oor_read7: got %h/%b want 0/%b", d, rs, EXP_OOR);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(ADDR_W'(i), d, rs);
      tests++; if (d !== exp_mem[i] || rs !== 2'b00) begin
        fails++; $display("FAIL mem_intact[%0d]: got %h/%b want %h/00", i, d, rs, exp_mem[i]);
      end
    end
  endtask

  task automatic test_midop_reset();
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    aw_valid = 1'b1; aw_addr = 3'd1;
    tick();
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = 4'h5;
    rst = 1'b1;
    tick();
    rst = 1'b0; w_valid = 1'b0;
    tick();
    tests++; if (led_reg !== 4'h0 || b_valid !== 1'b0) begin
      fails++; $display("FAIL midop_cleared: led=%h b_valid=%b want 0/0", led_reg, b_valid);
    end
    w_valid = 1'b1; w_data = 4'h6;
    tick();
    w_valid = 1'b0;
    tick(); tick();
    tests++; if (b_valid !== 1'b0 || {aw_ready, w_ready} !== 2'b10) begin
      fails++; $display("FAIL midop_no_commit: b_valid=%b ready=%b want 0/10", b_valid, {aw_ready, w_ready});
    end
    do_read(3'd1, d, rs);
    tests++; if (d !== 4'h0) begin
      fails++; $display("FAIL midop_read1: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_collision();
    test_out_of_range();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
